id_ex_control_stage: RTL



---
 rtl/rv_ctrl_pkg.sv | 38 +++
 rtl/id_ex_control_stage_if.sv | 41 ++++
 rtl/id_ex_control_stage_main_decoder.sv | 47 ++++
 rtl/id_ex_control_stage.sv | 90 +++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// ==== rv_ctrl_pkg : shared RV32I decode encodings and ID/EX control record | rev 1.0 ====
`default_nettype none

package rv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  // Control half of the ID/EX register; all-zero is the bubble.
  typedef struct packed {
    logic       valid;
    logic       illegal;
    ctrl_t      ctrl;
    logic [3:0] funct;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } id_ex_t;

endpackage

`default_nettype wire

// File: rtl/id_ex_control_stage_if.sv
// ==== id_ex_control_stage_if : ID-side inputs and ID/EX control outputs | rev 1.0 ====
`default_nettype none

interface id_ex_control_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] instr;
  logic            id_valid;
  logic            hold;
  logic            flush;
  logic            load_use_stall;
  logic            ex_valid;
  logic [1:0]      ex_ALUOp;
  logic [3:0]      ex_Funct;
  logic            ex_ALUSrc;
  logic            ex_RegWrite;
  logic            ex_MemRead;
  logic            ex_MemWrite;
  logic            ex_MemtoReg;
  logic            ex_Branch;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic            ex_illegal;

  modport master (
    output instr, id_valid, hold, flush,
    input  load_use_stall, ex_valid, ex_ALUOp, ex_Funct, ex_ALUSrc, ex_RegWrite,
           ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch, ex_rs1, ex_rs2, ex_rd,
           ex_illegal
  );

  modport slave (
    input  instr, id_valid, hold, flush,
    output load_use_stall, ex_valid, ex_ALUOp, ex_Funct, ex_ALUSrc, ex_RegWrite,
           ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch, ex_rs1, ex_rs2, ex_rd,
           ex_illegal
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_control_stage_main_decoder.sv
// ==== main_decoder : opcode -> main control bits, illegal flag, rs2 usage | rev 1.0 ====
`default_nettype none

module main_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       uses_rs2
);

  always_comb begin
    ctrl     = '0;
    illegal  = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.alu_op    = ALUOP_FUNCT;
        ctrl.reg_write = 1'b1;
        uses_rs2       = 1'b1;
      end
      OP_LOAD: begin
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_STORE: begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        uses_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.alu_op = ALUOP_SUB;
        ctrl.branch = 1'b1;
        uses_rs2    = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_control_stage.sv
// ==== id_ex_control_stage : ID decode, load-use hazard detect, ID/EX control register | rev 1.0 ====
`default_nettype none

module id_ex_control_stage
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  id_ex_control_stage_if.slave  bus
);

  logic [XLEN-1:0] instr;
  ctrl_t           dec_ctrl;
  logic            dec_illegal;
  logic            uses_rs2;
  id_ex_t          decoded;
  id_ex_t          ex_d;
  id_ex_t          ex_q;
  logic            hazard;
  logic            stall;
  logic            unused_instr_bits;

  assign instr             = bus.instr;
  assign unused_instr_bits = ^{instr[31], instr[29:25]};

  main_decoder u_main_decoder (
    .opcode   (instr[6:0]),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .uses_rs2 (uses_rs2)
  );

  always_comb begin
    decoded         = '0;
    decoded.valid   = 1'b1;
    decoded.illegal = dec_illegal;
    decoded.ctrl    = dec_ctrl;
    decoded.funct   = {instr[30], instr[14:12]};
    decoded.rs1     = instr[19:15];
    decoded.rs2     = instr[24:20];
    decoded.rd      = instr[11:7];
  end

  // A load to x0 never produces a value to wait for.
  assign hazard = bus.id_valid & ex_q.valid & ex_q.ctrl.mem_read & (ex_q.rd != 5'd0) &
                  ((ex_q.rd == decoded.rs1) | (uses_rs2 & (ex_q.rd == decoded.rs2)));
  assign stall  = hazard & ~bus.flush & ~bus.hold;

  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.hold) begin
      ex_d = ex_q;
    end else if (stall || !bus.id_valid) begin
      ex_d = '0;
    end else begin
      ex_d = decoded;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Outputs are additionally qualified by valid so no control bit can leak from a bubble.
  assign bus.load_use_stall = stall;
  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_illegal     = ex_q.valid & ex_q.illegal;
  assign bus.ex_ALUOp       = ex_q.valid ? ex_q.ctrl.alu_op : 2'b00;
  assign bus.ex_Funct       = ex_q.valid ? ex_q.funct : 4'd0;
  assign bus.ex_ALUSrc      = ex_q.valid & ex_q.ctrl.alu_src;
  assign bus.ex_RegWrite    = ex_q.valid & ex_q.ctrl.reg_write;
  assign bus.ex_MemRead     = ex_q.valid & ex_q.ctrl.mem_read;
  assign bus.ex_MemWrite    = ex_q.valid & ex_q.ctrl.mem_write;
  assign bus.ex_MemtoReg    = ex_q.valid & ex_q.ctrl.mem_to_reg;
  assign bus.ex_Branch      = ex_q.valid & ex_q.ctrl.branch;
  assign bus.ex_rs1         = ex_q.valid ? ex_q.rs1 : 5'd0;
  assign bus.ex_rs2         = ex_q.valid ? ex_q.rs2 : 5'd0;
  assign bus.ex_rd          = ex_q.valid ? ex_q.rd : 5'd0;

endmodule

`default_nettype wire
